// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame instruction cache between the fetch stage
// and the memory controller; misses fetch a single word and bypass it to the datapath.
module icache_responder #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iinvalidate,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic {IDLE, MISS} state_t;

  state_t             state;
  logic [SETS-1:0]    valid;
  logic [TAG_W-1:0]   tag_arr  [SETS];
  logic [31:0]        data_arr [SETS];
  logic [29:0]        miss_word;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               lookup_hit;
  logic               addr_match;
  logic               fill;
  logic               unused_offset;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  assign idx           = imemaddr[IDX_W+1:2];
  assign tag           = imemaddr[31:IDX_W+2];
  assign unused_offset = ^imemaddr[1:0];

  assign lookup_hit = imemREN && valid[idx] && (tag_arr[idx] == tag);
  assign addr_match = imemREN && (imemaddr[31:2] == miss_word);
  // Invalidate and reset both suppress the fill that would otherwise complete this cycle.
  assign fill       = (state == MISS) && addr_match && !iwait && !iinvalidate && !RST;

  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    if (!RST) begin
      if (state == MISS) begin
        iREN  = 1'b1;
        iaddr = {miss_word, 2'b00};
        if (fill) begin
          ihit     = 1'b1;
          imemload = iload;
        end
      end else if (lookup_hit && !iinvalidate) begin
        ihit     = 1'b1;
        imemload = data_arr[idx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      miss_word  <= '0;
    end else if (iinvalidate) begin
      valid <= '0;
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN) begin
            if (lookup_hit) begin
              hit_count <= sat_inc(hit_count);
            end else begin
              miss_word  <= imemaddr[31:2];
              miss_count <= sat_inc(miss_count);
              state      <= MISS;
            end
          end
        end
        MISS: begin
          // A dropped or redirected request abandons the miss; IDLE re-looks it up.
          if (!addr_match) begin
            state <= IDLE;
          end else if (!iwait) begin
            valid[idx] <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_arr[idx]  <= tag;
      data_arr[idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed scoreboard bench for icache_responder: expectations are queued per
// cycle as stimulus is driven and popped when the outputs are sampled mid-cycle.
module tb_icache_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iinvalidate;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] load;
    logic        ren;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   exp_hits   = 0;
  int   exp_miss   = 0;

  icache_responder #(.SETS(16)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload),
    .iinvalidate(iinvalidate),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, sample at the falling edge.
  task automatic cyc(input string name, input logic ren, input logic [31:0] addr,
                     input logic wt, input logic [31:0] ld, input logic inv,
                     input logic e_hit, input logic [31:0] e_load,
                     input logic e_ren, input logic [31:0] e_addr);
    exp_t e;
    imemREN     = ren;
    imemaddr    = addr;
    iwait       = wt;
    iload       = ld;
    iinvalidate = inv;
    e.name = name; e.hit = e_hit; e.load = e_load; e.ren = e_ren; e.addr = e_addr;
    sb.push_back(e);
    #4;
    e = sb.pop_front();
    chk({e.name, "_ihit"},     {31'd0, ihit}, {31'd0, e.hit});
    chk({e.name, "_imemload"}, imemload,      e.load);
    chk({e.name, "_iREN"},     {31'd0, iREN}, {31'd0, e.ren});
    chk({e.name, "_iaddr"},    iaddr,         e.addr);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_read(input string name, input logic [31:0] addr,
                           input logic hit, input logic [31:0] data);
    if (hit) exp_hits++;
    else     exp_miss++;
    cyc(name, 1'b1, addr, 1'b0, 32'h0BAD_F00D, 1'b0, hit, hit ? data : 32'h0, 1'b0, 32'h0);
  endtask

  task automatic miss_fill(input string name, input logic [31:0] addr,
                           input int nwait, input logic [31:0] data);
    logic [31:0] aligned;
    aligned = {addr[31:2], 2'b00};
    idle_read({name, "_lookup"}, addr, 1'b0, 32'h0);
    for (int i = 0; i < nwait; i++)
      cyc({name, "_wait"}, 1'b1, addr, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h0, 1'b1, aligned);
    cyc({name, "_fill"}, 1'b1, addr, 1'b0, data, 1'b0, 1'b1, data, 1'b1, aligned);
  endtask

  task automatic counters(input string name);
    chk({name, "_hit_count"},  hit_count,  exp_hits);
    chk({name, "_miss_count"}, miss_count, exp_miss);
  endtask

  initial begin
    RST         = 1'b1;
    imemREN     = 1'b1;
    imemaddr    = 32'h40;
    iwait       = 1'b0;
    iload       = 32'h1234_5678;
    iinvalidate = 1'b0;
    @(posedge CLK);
    #1;
    cyc("reset", 1'b1, 32'h40, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    RST = 1'b0;
    counters("reset");

    // Cold miss with two wait cycles, then same-cycle hit and byte-offset alias.
    miss_fill("cold40", 32'h40, 2, 32'h2001_0005);
    counters("cold40");
    idle_read("rehit40", 32'h40, 1'b1, 32'h2001_0005);
    idle_read("byte43", 32'h43, 1'b1, 32'h2001_0005);
    counters("rehit40");

    // Conflict eviction on index 0.
    miss_fill("conf0", 32'h0, 0, 32'hAAAA_0000);
    miss_fill("conf40", 32'h40, 0, 32'hBBBB_0000);
    miss_fill("conf0b", 32'h0, 1, 32'hAAAA_0000);
    idle_read("conf0hit", 32'h0, 1'b1, 32'hAAAA_0000);
    counters("conflict");

    // Abort by address change mid-miss.
    idle_read("abort80_lookup", 32'h80, 1'b0, 32'h0);
    cyc("abort80_wait", 1'b1, 32'h80, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
    cyc("abort80_redir", 1'b1, 32'h84, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
    miss_fill("new84", 32'h84, 0, 32'h8484_8484);
    idle_read("hit84", 32'h84, 1'b1, 32'h8484_8484);
    miss_fill("re80", 32'h80, 0, 32'h8080_8080);
    counters("abort");

    // Abort by dropping the request, then an idle cycle with no request.
    idle_read("dropC0_lookup", 32'hC0, 1'b0, 32'h0);
    cyc("dropC0_abort", 1'b0, 32'hC0, 1'b0, 32'hC0C0_C0C0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC0);
    cyc("norequest", 1'b0, 32'hC0, 1'b0, 32'hC0C0_C0C0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle_read("dropC0_relookup", 32'hC0, 1'b0, 32'h0);
    cyc("dropC0_fill", 1'b1, 32'hC0, 1'b0, 32'hC0C0_C0C0, 1'b0, 1'b1, 32'hC0C0_C0C0, 1'b1, 32'hC0);
    counters("drop");

    // Invalidate from IDLE and from MISS.
    miss_fill("f10", 32'h10, 0, 32'h1010_1010);
    idle_read("hit10", 32'h10, 1'b1, 32'h1010_1010);
    cyc("inv_idle", 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    counters("inv_idle");
    idle_read("inv10_lookup", 32'h10, 1'b0, 32'h0);
    cyc("inv10_wait", 1'b1, 32'h10, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
    cyc("inv_miss", 1'b1, 32'h10, 1'b0, 32'h5555_5555, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10);
    cyc("inv_drop", 1'b0, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    miss_fill("post_inv0", 32'h0, 0, 32'hAAAA_0000);
    miss_fill("post_inv84", 32'h84, 0, 32'h8484_8484);
    miss_fill("post_inv10", 32'h10, 0, 32'h1010_1010);
    idle_read("post_inv10_hit", 32'h10, 1'b1, 32'h1010_1010);
    counters("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
